// File: rtl/collatz_range_if.sv
// Control/readback bus between the display front end and the collatz_range engine.
interface collatz_range_if;
    logic        go;
    logic [31:0] start;
    logic        done;
    logic [15:0] count;

    modport master (output go, start, input done, count);
    modport slave  (input go, start, output done, count);
endinterface

// File: rtl/collatz_range.sv
// Evaluates Collatz sequence lengths for RAM_WORDS consecutive start values,
// stores them in a result RAM, then serves synchronous readback.
module collatz_range #(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    collatz_range_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [31:0]              base;
    logic [31:0]              n;
    logic [RAM_ADDR_BITS-1:0] i;
    logic [15:0]              cnt;
    logic                     done;
    logic [15:0]              count;
    logic [15:0]              mem [RAM_WORDS];

    logic terminal, last;
    assign terminal = (n == 32'd0) || (n == 32'd1);
    assign last     = (i == RAM_ADDR_BITS'(RAM_WORDS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.go) state_nxt = LOAD;
            LOAD:       state_nxt = RUN;
            RUN:        if (terminal) state_nxt = last ? DONE : LOAD;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            count <= 16'h0000;
            i     <= '0;
            n     <= 32'd0;
            cnt   <= 16'h0000;
            base  <= 32'd0;
        end else begin
            state <= state_nxt;
            // A go in DONE leaves the engine, so the readback must already show zero in LOAD.
            count <= (state == DONE && !bus.go) ? mem[bus.start[RAM_ADDR_BITS-1:0]] : 16'h0000;
            case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        base <= bus.start;
                        i    <= '0;
                        done <= 1'b0;
                    end
                end
                LOAD: begin
                    n   <= base + 32'(i);
                    cnt <= 16'h0001;
                end
                RUN: begin
                    if (terminal) begin
                        if (last) done <= 1'b1;
                        else      i    <= i + RAM_ADDR_BITS'(1);
                    end else begin
                        n   <= n[0] ? (n << 1) + n + 32'd1 : n >> 1;
                        cnt <= cnt + 16'h0001;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write port kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && state == RUN && terminal)
            mem[i] <= (n == 32'd1) ? cnt : 16'h0000;
    end

    assign bus.done  = done;
    assign bus.count = count;
endmodule

// File: tb/tb_collatz_range.sv
// Randomized self-checking bench for collatz_range with a sequence-length reference model.
module tb_collatz_range;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    collatz_range_if bus ();
    collatz_range_if big ();

    collatz_range #(.RAM_WORDS(4), .RAM_ADDR_BITS(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    collatz_range dut_big (.clk(clk), .reset(reset), .bus(big));

    int checks = 0;
    int errors = 0;

    // Reference model: whole-run view, no notion of the engine's internal steps.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_count = 16'h0000;
    int          m_left = 0;
    logic [15:0] m_res [4];
    logic [15:0] m_mem [4];

    function automatic void clen(input logic [31:0] v0, output logic [15:0] stored, output int edges);
        logic [31:0] v;
        int it;
        v  = v0;
        it = 1;
        if (v == 32'd0) begin
            stored = 16'h0000;
            edges  = 1;
            return;
        end
        while (v != 32'd1 && it < 1000000) begin
            v = v[0] ? v * 32'd3 + 32'd1 : v >> 1;
            it++;
        end
        stored = 16'(it);
        edges  = it;
    endfunction

    task automatic model_update(input logic g, input logic [31:0] s, input logic r);
        logic [15:0] st;
        int e, total;
        if (r) begin
            m_busy = 1'b0; m_done = 1'b0; m_count = 16'h0000;
        end else if (m_busy) begin
            m_count = 16'h0000;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                for (int j = 0; j < 4; j++) m_mem[j] = m_res[j];
            end
        end else if (g) begin
            total = 0;
            for (int j = 0; j < 4; j++) begin
                clen(s + 32'(j), st, e);
                m_res[j] = st;
                total += e + 1;
            end
            m_left = total; m_busy = 1'b1; m_done = 1'b0; m_count = 16'h0000;
        end else begin
            m_count = m_done ? m_mem[s[1:0]] : 16'h0000;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, model follows the edge, compare at the next negedge.
    task automatic step(input logic g, input logic [31:0] s, input logic r, input logic bg);
        bus.go = g; bus.start = s; reset = r;
        big.go = bg; big.start = s;
        @(posedge clk);
        #1;
        model_update(g, s, r);
        @(negedge clk);
        chk("model_done", 32'(bus.done), 32'(m_done));
        chk("model_count", 32'(bus.count), 32'(m_count));
    endtask

    task automatic wait_done(input int bound, input bit noise, input bit use_big, output int edges);
        logic g;
        edges = 0;
        while (!(use_big ? big.done : bus.done) && edges < bound) begin
            g = noise && ($urandom_range(0, 5) == 0);
            step(g, $urandom, 1'b0, 1'b0);
            edges++;
        end
        if (!(use_big ? big.done : bus.done)) begin
            errors++;
            $display("FAIL done_timeout actual=%0d expected<%0d", edges, bound);
        end
    endtask

    initial begin
        int e;
        logic [15:0] st;
        bus.go = 1'b0; bus.start = 32'd0; big.go = 1'b0; big.start = 32'd0;
        @(negedge clk);

        clen(32'd27, st, e);  chk("model_len27", 32'(st), 32'd112);
        clen(32'd3, st, e);   chk("model_len3", 32'(st), 32'd8);
        clen(32'd256, st, e); chk("model_len256", 32'(st), 32'd9);

        step(1'b1, 32'd1, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_count", 32'(bus.count), 32'd0);

        // start=1: counts 1,2,8,3, done after 18 edges
        step(1'b1, 32'd1, 1'b0, 1'b0);
        wait_done(500, 1'b0, 1'b0, e);
        chk("lat_start1", 32'(e), 32'd18);
        step(1'b0, 32'd0, 1'b0, 1'b0); chk("rd0", 32'(bus.count), 32'd1);
        step(1'b0, 32'd1, 1'b0, 1'b0); chk("rd1", 32'(bus.count), 32'd2);
        step(1'b0, 32'd2, 1'b0, 1'b0); chk("rd2", 32'(bus.count), 32'd8);
        step(1'b0, 32'd3, 1'b0, 1'b0); chk("rd3", 32'(bus.count), 32'd3);

        // start=0: zero stored for 0, done after 16 edges
        step(1'b1, 32'd0, 1'b0, 1'b0);
        chk("restart_done_low", 32'(bus.done), 32'd0);
        wait_done(500, 1'b0, 1'b0, e);
        chk("lat_start0", 32'(e), 32'd16);
        step(1'b0, 32'd0, 1'b0, 1'b0); chk("rd0_zero", 32'(bus.count), 32'd0);
        step(1'b0, 32'd3, 1'b0, 1'b0); chk("rd3_start0", 32'(bus.count), 32'd8);

        // go pulsed 3 cycles into a run is ignored
        step(1'b1, 32'd1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd27, 1'b0, 1'b0);
        wait_done(500, 1'b0, 1'b0, e);
        chk("lat_ignored_go", 32'(e + 3), 32'd18);
        step(1'b0, 32'd2, 1'b0, 1'b0); chk("rd2_ignored_go", 32'(bus.count), 32'd8);

        // reset 5 cycles into a run aborts; a fresh run then completes
        step(1'b1, 32'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_count", 32'(bus.count), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd1, 1'b0, 1'b0);
        wait_done(500, 1'b0, 1'b0, e);
        chk("lat_after_abort", 32'(e), 32'd18);
        step(1'b0, 32'd1, 1'b0, 1'b0); chk("rd1_after_abort", 32'(bus.count), 32'd2);

        // restart from DONE with start=27
        step(1'b1, 32'd27, 1'b0, 1'b0);
        chk("done_falls_27", 32'(bus.done), 32'd0);
        chk("count_zero_load", 32'(bus.count), 32'd0);
        wait_done(2000, 1'b1, 1'b0, e);
        step(1'b0, 32'hABCD_EF00, 1'b0, 1'b0); chk("rd0_27", 32'(bus.count), 32'd112);

        // randomized runs with noisy go during runs and random upper address bits
        for (int r = 0; r < 8; r++) begin
            step(1'b1, 32'($urandom_range(0, 3000)), 1'b0, 1'b0);
            wait_done(3000, 1'b1, 1'b0, e);
            for (int k = 0; k < 6; k++) step(1'b0, $urandom, 1'b0, 1'b0);
        end

        // default-size instance: 1..256, address 0xFF holds the count for 256
        step(1'b0, 32'd1, 1'b0, 1'b1);
        wait_done(20000, 1'b0, 1'b1, e);
        step(1'b0, 32'h0000_00FF, 1'b0, 1'b0); chk("big_rd_ff", 32'(big.count), 32'd9);
        step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0); chk("big_rd_ff_upper", 32'(big.count), 32'd9);
        step(1'b0, 32'hFFFF_FF1A, 1'b0, 1'b0); chk("big_rd_1a_upper", 32'(big.count), 32'd112);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
